uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Round-robin, packet-locked arbiter that shares the single UART transmit path among `NUM_REQ` independent byte-stream requesters. It sits between the requesting client blocks and the UART write port (`W_data`/`wr_uart`/`tx_full`). It grants one requester at a time and holds the grant until that requester's last byte is accepted. Multi-byte messages are therefore never interleaved on the serial line.

## Interface
Parameters:
- `NUM_REQ`, 4, number of requesters (≥2)
- `DATA_WIDTH`, 8, byte width; matches the UART `DATA_WIDTH`
- `ID_W`, `$clog2(NUM_REQ)`, width of `grant_id`

Ports:
- `UCLK` input 1: single clock, shared with the UART
- `reset` input 1: synchronous, active-high
- `req_valid` input `NUM_REQ`: requester i has a byte on its `req_data` slice
- `req_data` input `NUM_REQ*DATA_WIDTH`: requester i byte at bits `[i*DATA_WIDTH +: DATA_WIDTH]`
- `req_last` input `NUM_REQ`: current byte of requester i is the final byte of its packet
- `req_ready` output `NUM_REQ`: byte of requester i accepted this cycle (one-hot or zero)
- `W_data` output `DATA_WIDTH`: byte to the UART transmit FIFO
- `wr_uart` output 1: write strobe to the UART
- `tx_full` input 1: UART transmit FIFO full
- `grant_id` output `ID_W`: index of the current or most recent grantee
- `busy` output 1: a packet is in progress (state XFER)
- `pkt_done` output 1: single-cycle pulse when the last byte of a packet is written

## Operation
- FSM has two states, IDLE and XFER. A registered round-robin pointer `last_grant` tracks the most recently granted requester.
- **IDLE:** if any `req_valid` bit is set, select the first set bit searching from `(last_grant+1) mod NUM_REQ` upward, with wrap. Register the selection into `grant_id` and `last_grant`, and go to XFER. No byte is transferred in IDLE. If no request is present, stay in IDLE.
- **XFER** (g = `grant_id`):
  - `wr_uart = req_valid[g] & ~tx_full`
  - `req_ready[g] = wr_uart`; all other `req_ready` bits are 0
  - `W_data = req_data[g]`; the value is don't-care when `wr_uart`=0
  - If `wr_uart & req_last[g]`, pulse `pkt_done` in the same cycle and go to IDLE next cycle.
  - Otherwise stay in XFER. If the grantee drops `req_valid` mid-packet, the lock is held and the arbiter waits indefinitely; there is no timeout.
- `req_valid`/`req_data`/`req_last` of non-granted requesters are ignored. A requester must hold its byte stable until `req_ready` is asserted.
- `wr_uart`, `req_ready` and `pkt_done` are combinational from state and inputs. `grant_id`, `busy` and `last_grant` are registered.
- Reset values: state IDLE, `grant_id`=0, `last_grant`=`NUM_REQ-1` (so requester 0 has first priority), `busy`=0, `wr_uart`=0, `req_ready`=0, `pkt_done`=0.

## Timing
- **Arbitration latency:** `req_valid` seen in IDLE at cycle n; the grant is registered at the end of n; the earliest `wr_uart` is cycle n+1.
- **Throughput:** 1 byte per cycle while `tx_full`=0 and `req_valid[g]`=1.
- **Inter-packet bubble:** exactly one IDLE cycle between the last byte of one packet and the first byte of the next, even when the same or another requester is waiting.
- **Single-byte packet** (`req_last`=1 on the first byte): XFER lasts 1 cycle if not full, then returns to IDLE.
- **`tx_full` asserted in XFER:** `wr_uart`=0 and `req_ready`=0; the byte is held with no loss and no duplication. Transfer resumes in the first cycle `tx_full`=0.
- **`tx_full` and `req_last` in the same cycle:** no write occurs and the FSM stays in XFER.
- **Synchronous `reset` mid-packet:** the packet is abandoned. The next cycle is IDLE with the reset values and no `wr_uart`. Bytes already written remain in the UART FIFO.
- **Requests arriving while XFER:** they queue implicitly through held `req_valid` and are arbitrated in the next IDLE cycle.
- **Pointer wrap:** after grant `NUM_REQ-1`, the search starts at 0.

## Test plan
- **Reset, then all 4 requesters valid with 1-byte packets** (data 0xA0..0xA3, `req_last`=1, held) → grants in order 0,1,2,3. `W_data` sequence is A0,A1,A2,A3. Each `wr_uart` is separated by one idle cycle. 4 `pkt_done` pulses.
- **Requester 2 sends 3-byte packet 0x11,0x22,0x33 while requester 0 is valid from cycle 1** → all three bytes of requester 2 are written on consecutive cycles before any requester 0 byte. Requester 0 is granted after the 1-cycle bubble.
- **`tx_full` held high for 5 cycles mid-packet** → no `wr_uart` and `req_ready`=0 for those 5 cycles. The stalled byte is written exactly once after `tx_full` falls.
- **Grantee 1 drops `req_valid` for 3 cycles mid-packet while requester 3 is valid** → `busy` stays 1, `grant_id` stays 1, and requester 3 gets no `req_ready` until requester 1's `req_last` byte is written.
- **Assert `reset` for 1 cycle during byte 2 of a 4-byte packet** → next cycle `busy`=0, `grant_id`=0, `wr_uart`=0. With requesters 0 and 1 then valid, requester 0 is granted first.
- **Fairness over 40 packets with all requesters continuously valid** → each requester receives exactly 10 grants. `grant_id` wraps 3→0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, packet-locked arbiter sharing one UART transmit port
module uart_tx_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_W = $clog2(NUM_REQ)
) (
  input  logic                          UCLK,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         W_data,
  output logic                          wr_uart,
  input  logic                          tx_full,
  output logic [ID_W-1:0]               grant_id,
  output logic                          busy,
  output logic                          pkt_done
);
  typedef enum logic {IDLE, XFER} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] last_grant, grant_n, sel, idx;
  logic found;
  always_comb begin
    found = 1'b0;
    sel = '0;
    idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = ID_W'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel = idx;
      end
    end
  end
  assign busy = state == XFER;
  assign wr_uart = busy & req_valid[grant_id] & ~tx_full;
  assign req_ready = wr_uart ? NUM_REQ'(1) << grant_id : '0;
  assign W_data = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign pkt_done = wr_uart & req_last[grant_id];
  // grant_id doubles as the in-packet lock; last_grant only moves on a new grant
  always_comb begin
    state_n = state;
    grant_n = grant_id;
    if (state == IDLE && found) begin
      state_n = XFER;
      grant_n = sel;
    end
    if (pkt_done) state_n = IDLE;
  end
  always_ff @(posedge UCLK) begin
    if (reset) begin
      state <= IDLE;
      grant_id <= '0;
      last_grant <= ID_W'(NUM_REQ - 1);
    end else begin
      state <= state_n;
      grant_id <= grant_n;
      last_grant <= (state == IDLE && found) ? sel : last_grant;
    end
  end
endmodule
